// File: rtl/simon_decrypt_core_if.sv
// Host handshake bundle for simon_decrypt_core (newX/ldX/doneX/readData style).
// The enc_dec select exists only when SIMON_DEC_ENCRYPT_EN is defined.
interface simon_decrypt_core_if #(
   parameter int unsigned N = 16,
   parameter int unsigned M = 4
) ();
   logic                newKey;
   logic [M-1:0][N-1:0] key;
   logic                newData;
   logic [2*N-1:0]      cipher;
   logic                readData;
   logic                ldKey;
   logic                ldData;
   logic                doneKey;
   logic                doneData;
   logic                busy;
   logic [2*N-1:0]      plain;
`ifdef SIMON_DEC_ENCRYPT_EN
   logic                enc_dec;
`endif

   modport master (
`ifdef SIMON_DEC_ENCRYPT_EN
      output enc_dec,
`endif
      output newKey, key, newData, cipher, readData,
      input  ldKey, ldData, doneKey, doneData, busy, plain
   );

   modport slave (
`ifdef SIMON_DEC_ENCRYPT_EN
      input  enc_dec,
`endif
      input  newKey, key, newData, cipher, readData,
      output ldKey, ldData, doneKey, doneData, busy, plain
   );
endinterface

// File: rtl/simon_decrypt_core.sv
// Iterative SIMON decryptor: stores the full expanded key schedule, then runs T inverse rounds.
// Define SIMON_DEC_ENCRYPT_EN to add a forward (encrypt) mode selected by enc_dec at data capture.
module simon_decrypt_core #(
   parameter int unsigned N = 16,
   parameter int unsigned M = 4,
   parameter int unsigned T = 32,
   parameter int unsigned C = 5,
   parameter logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
   input logic                 clk,
   input logic                 R,
   simon_decrypt_core_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC, S_DONE} state_t;

   localparam logic [C-1:0] LP_M   = C'(M);
   localparam logic [C-1:0] LP_TM1 = C'(T - 1);
   localparam logic [N-1:0] LP_C3  = N'(3);

   function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
      return (v << s) | (v >> (N - s));
   endfunction

   function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned s);
      return (v >> s) | (v << (N - s));
   endfunction

   function automatic logic [N-1:0] f_simon(input logic [N-1:0] v);
      return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
   endfunction

   state_t         r_state, w_state_nxt;
   logic [N-1:0]   r_keys [0:T-1];
   logic [C-1:0]   r_cnt;
   logic           r_pending, r_done_key, r_done_data, r_ld_key, r_ld_data;
   logic [N-1:0]   r_x, r_y;
   logic [2*N-1:0] r_plain;

   logic           w_enc, w_enc_sel;
   logic           w_open, w_acc_key, w_acc_data, w_busy, w_kexp_last, w_rnd_last;
   logic [C-1:0]   w_ia, w_ib, w_ic, w_cnt_new, w_cnt_pend;
   logic [5:0]     w_zpos;
   logic [N-1:0]   w_tmp, w_knew, w_kr, w_rx, w_ry;

`ifdef SIMON_DEC_ENCRYPT_EN
   logic r_enc;

   always_ff @(posedge clk or posedge R) begin
      if (R)               r_enc <= 1'b0;
      else if (w_acc_data) r_enc <= bus.enc_dec;
   end

   assign w_enc     = r_enc;
   assign w_enc_sel = bus.enc_dec;
`else
   assign w_enc     = 1'b0;
   assign w_enc_sel = 1'b0;
`endif

   // First round-key index: top of the schedule when decrypting, bottom when encrypting
   assign w_cnt_new  = w_enc_sel ? '0 : LP_TM1;
   assign w_cnt_pend = w_enc     ? '0 : LP_TM1;

   always_ff @(posedge clk or posedge R) begin
      if (R) r_state <= S_IDLE;
      else   r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_acc_key)       w_state_nxt = S_KEXP;
            else if (w_acc_data) w_state_nxt = S_DEC;
            else if (w_open)     w_state_nxt = S_IDLE;
         end
         S_KEXP:  if (w_kexp_last) w_state_nxt = r_pending ? S_DEC : S_IDLE;
         S_DEC:   if (w_rnd_last)  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // DONE acknowledged by readData behaves exactly like IDLE for new requests
   always_comb begin
      w_open      = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.readData);
      w_acc_key   = w_open && bus.newKey;
      w_acc_data  = w_open && bus.newData && (bus.newKey || r_done_key);
      w_busy      = (r_state == S_KEXP) || (r_state == S_DEC);
      w_kexp_last = (r_state == S_KEXP) && (r_cnt == LP_TM1);
      w_rnd_last  = (r_state == S_DEC) && (w_enc ? (r_cnt == LP_TM1) : (r_cnt == '0));
   end

   always_comb begin
      w_ia   = r_cnt - LP_M;
      w_ib   = r_cnt - C'(1);
      w_ic   = w_ia + C'(1);
      w_zpos = 6'(61 - (32'(w_ia) % 62));
      w_tmp  = rotr(r_keys[w_ib], 3);
      if (M == 4) w_tmp = w_tmp ^ r_keys[w_ic];
      w_tmp  = w_tmp ^ rotr(w_tmp, 1);
      w_knew = ~r_keys[w_ia] ^ w_tmp ^ N'(Z[w_zpos]) ^ LP_C3;
   end

   always_comb begin
      w_kr = r_keys[r_cnt];
      if (w_enc) begin
         w_rx = r_y ^ f_simon(r_x) ^ w_kr;
         w_ry = r_x;
      end else begin
         w_rx = r_y;
         w_ry = r_x ^ f_simon(r_y) ^ w_kr;
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc_key) begin
         for (int unsigned j = 0; j < M; j++) r_keys[j] <= bus.key[j];
      end else if (r_state == S_KEXP) begin
         r_keys[r_cnt] <= w_knew;
      end
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         r_cnt       <= '0;
         r_pending   <= 1'b0;
         r_done_key  <= 1'b0;
         r_done_data <= 1'b0;
         r_ld_key    <= 1'b0;
         r_ld_data   <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_plain     <= '0;
      end else begin
         r_ld_key  <= w_acc_key;
         r_ld_data <= w_acc_data;
         if (w_open) r_done_data <= 1'b0;
         if (w_acc_data) begin
            r_x <= bus.cipher[2*N-1:N];
            r_y <= bus.cipher[N-1:0];
         end
         if (w_acc_key) begin
            r_done_key <= 1'b0;
            r_pending  <= w_acc_data;
            r_cnt      <= LP_M;
         end else if (w_acc_data) begin
            r_cnt <= w_cnt_new;
         end
         case (r_state)
            S_KEXP: begin
               if (w_kexp_last) begin
                  r_done_key <= 1'b1;
                  r_pending  <= 1'b0;
                  r_cnt      <= r_pending ? w_cnt_pend : '0;
               end else begin
                  r_cnt <= r_cnt + C'(1);
               end
            end
            S_DEC: begin
               r_x <= w_rx;
               r_y <= w_ry;
               if (w_rnd_last) begin
                  r_plain     <= {w_rx, w_ry};
                  r_done_data <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= w_enc ? (r_cnt + C'(1)) : (r_cnt - C'(1));
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ldKey    = r_ld_key;
   assign bus.ldData   = r_ld_data;
   assign bus.doneKey  = r_done_key;
   assign bus.doneData = r_done_data;
   assign bus.busy     = w_busy;
   assign bus.plain    = r_plain;
endmodule

// File: tb/tb_simon_decrypt_core.sv
// Self-checking bench for simon_decrypt_core (SIMON32/64): vector table, handshake corners,
// reference model of the cipher. Encrypt-mode checks are built when SIMON_DEC_ENCRYPT_EN is defined.
module tb_simon_decrypt_core;
   localparam logic [63:0] K0  = 64'h1918_1110_0908_0100;
   localparam logic [31:0] CT0 = 32'hc69b_e9bb;
   localparam logic [31:0] PT0 = 32'h6565_6877;

   logic  clk = 1'b0;
   logic  R;
   int    n_checks = 0;
   int    n_fail = 0;
   string ZS = "11111010001001010110000111001101111101000100101011000011100110";

   typedef struct {
      logic [63:0] key;
      logic [31:0] ct;
      logic [31:0] pt;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   simon_decrypt_core_if #(.N(16), .M(4)) bus ();

   simon_decrypt_core #(.N(16), .M(4), .T(32), .C(5)) dut (
      .clk (clk),
      .R   (R),
      .bus (bus)
   );

   function automatic logic [15:0] rl(input logic [15:0] x, input int s);
      logic [31:0] d;
      d = {x, x};
      return d[31-s -: 16];
   endfunction

   function automatic logic [15:0] ff(input logic [15:0] x);
      return (rl(x, 1) & rl(x, 8)) ^ rl(x, 2);
   endfunction

   function automatic logic [511:0] sched(input logic [63:0] key);
      logic [15:0]  k [32];
      logic [15:0]  t;
      logic [511:0] r;
      for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
      for (int i = 0; i < 28; i++) begin
         t = rl(k[i+3], 13) ^ k[i+1];
         t = t ^ rl(t, 15);
         k[i+4] = 16'hfffc ^ k[i] ^ t ^ ((ZS[i % 62] == 8'h31) ? 16'd1 : 16'd0);
      end
      for (int i = 0; i < 32; i++) r[16*i +: 16] = k[i];
      return r;
   endfunction

   function automatic logic [31:0] model_dec(input logic [63:0] key, input logic [31:0] ct);
      logic [511:0] ks;
      logic [15:0]  x, y, t;
      ks = sched(key);
      x = ct[31:16];
      y = ct[15:0];
      for (int i = 31; i >= 0; i--) begin
         t = x ^ ff(y) ^ ks[16*i +: 16];
         x = y;
         y = t;
      end
      return {x, y};
   endfunction

   function automatic logic [31:0] model_enc(input logic [63:0] key, input logic [31:0] pt);
      logic [511:0] ks;
      logic [15:0]  x, y, t;
      ks = sched(key);
      x = pt[31:16];
      y = pt[15:0];
      for (int i = 0; i < 32; i++) begin
         t = y ^ ff(x) ^ ks[16*i +: 16];
         y = x;
         x = t;
      end
      return {x, y};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_key(output int cyc);
      cyc = 0;
      while (bus.doneKey !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_data(output int cyc);
      cyc = 0;
      while (bus.doneData !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic release_data(input string nm);
      bus.readData = 1'b1;
      @(negedge clk);
      bus.readData = 1'b0;
      check({nm, " doneData clr"}, 64'(bus.doneData), 64'd0);
   endtask

   task automatic load_key(input logic [63:0] k, input string nm);
      int cyc;
      @(negedge clk);
      bus.newKey = 1'b1;
      bus.key    = k;
      @(negedge clk);
      bus.newKey = 1'b0;
      check({nm, " ldKey"}, 64'(bus.ldKey), 64'd1);
      check({nm, " kexp busy"}, 64'(bus.busy), 64'd1);
      wait_key(cyc);
      check({nm, " key latency"}, 64'(cyc), 64'd28);
   endtask

   task automatic run_data(input logic [31:0] ct, input logic [31:0] pt, input string nm);
      int cyc;
      @(negedge clk);
      bus.newData = 1'b1;
      bus.cipher  = ct;
      @(negedge clk);
      bus.newData = 1'b0;
      check({nm, " ldData"}, 64'(bus.ldData), 64'd1);
      check({nm, " dec busy"}, 64'(bus.busy), 64'd1);
      wait_data(cyc);
      check({nm, " data latency"}, 64'(cyc), 64'd32);
      check({nm, " plain"}, 64'(bus.plain), 64'(pt));
      repeat (3) @(negedge clk);
      check({nm, " doneData hold"}, 64'(bus.doneData), 64'd1);
      check({nm, " plain hold"}, 64'(bus.plain), 64'(pt));
      release_data(nm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      logic [63:0] k2;
      logic [31:0] c1, c2, e1;

      R            = 1'b1;
      bus.newKey   = 1'b0;
      bus.key      = '0;
      bus.newData  = 1'b0;
      bus.cipher   = '0;
      bus.readData = 1'b0;
`ifdef SIMON_DEC_ENCRYPT_EN
      bus.enc_dec  = 1'b0;
`endif

      vecs[0] = '{key: K0, ct: CT0, pt: PT0};
      for (int i = 1; i < 5; i++) begin
         vecs[i].key = {$urandom(), $urandom()};
         vecs[i].ct  = $urandom();
         vecs[i].pt  = model_dec(vecs[i].key, vecs[i].ct);
      end

      repeat (3) @(negedge clk);
      check("rst ldKey", 64'(bus.ldKey), 64'd0);
      check("rst ldData", 64'(bus.ldData), 64'd0);
      check("rst doneKey", 64'(bus.doneKey), 64'd0);
      check("rst doneData", 64'(bus.doneData), 64'd0);
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst plain", 64'(bus.plain), 64'd0);
      R = 1'b0;

      // ciphertext before any key is ignored
      @(negedge clk);
      bus.newData = 1'b1;
      bus.cipher  = CT0;
      @(negedge clk);
      bus.newData = 1'b0;
      check("nokey ldData", 64'(bus.ldData), 64'd0);
      check("nokey busy", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      check("nokey doneData", 64'(bus.doneData), 64'd0);

      for (int i = 0; i < 5; i++) begin
         load_key(vecs[i].key, $sformatf("v%0d", i));
         run_data(vecs[i].ct, vecs[i].pt, $sformatf("v%0d", i));
      end

      // requests during DEC are ignored
      c1 = $urandom();
      @(negedge clk);
      bus.newData = 1'b1;
      bus.cipher  = c1;
      @(negedge clk);
      bus.newData = 1'b0;
      check("decign ldData start", 64'(bus.ldData), 64'd1);
      cyc = 0;
      while (bus.doneData !== 1'b1 && cyc < 200) begin
         if (cyc == 5) begin
            bus.newData = 1'b1;
            bus.newKey  = 1'b1;
            bus.cipher  = ~c1;
            bus.key     = K0;
         end
         @(negedge clk);
         cyc++;
         if (cyc == 6) begin
            check("decign ldData", 64'(bus.ldData), 64'd0);
            check("decign ldKey", 64'(bus.ldKey), 64'd0);
            bus.newData = 1'b0;
            bus.newKey  = 1'b0;
         end
      end
      check("decign latency", 64'(cyc), 64'd32);
      check("decign plain", 64'(bus.plain), 64'(model_dec(vecs[4].key, c1)));
      check("decign doneKey", 64'(bus.doneKey), 64'd1);

      // DONE: newData without readData is ignored
      c2 = $urandom();
      bus.newData = 1'b1;
      bus.cipher  = c2;
      @(negedge clk);
      bus.newData = 1'b0;
      check("done noack ldData", 64'(bus.ldData), 64'd0);
      check("done noack doneData", 64'(bus.doneData), 64'd1);

      // DONE: readData with newData restarts immediately
      bus.readData = 1'b1;
      bus.newData  = 1'b1;
      bus.cipher   = c2;
      @(negedge clk);
      bus.readData = 1'b0;
      bus.newData  = 1'b0;
      check("ack+data ldData", 64'(bus.ldData), 64'd1);
      check("ack+data doneData", 64'(bus.doneData), 64'd0);
      check("ack+data busy", 64'(bus.busy), 64'd1);
      wait_data(cyc);
      check("ack+data latency", 64'(cyc), 64'd32);
      check("ack+data plain", 64'(bus.plain), 64'(model_dec(vecs[4].key, c2)));

      // DONE: readData with newKey reloads the schedule
      k2 = {$urandom(), $urandom()};
      bus.readData = 1'b1;
      bus.newKey   = 1'b1;
      bus.key      = k2;
      @(negedge clk);
      bus.readData = 1'b0;
      bus.newKey   = 1'b0;
      check("ack+key ldKey", 64'(bus.ldKey), 64'd1);
      check("ack+key doneData", 64'(bus.doneData), 64'd0);
      check("ack+key doneKey", 64'(bus.doneKey), 64'd0);
      wait_key(cyc);
      check("ack+key latency", 64'(cyc), 64'd28);
      run_data(c1, model_dec(k2, c1), "k2");

      // key and data in the same cycle
      @(negedge clk);
      bus.newKey  = 1'b1;
      bus.newData = 1'b1;
      bus.key     = K0;
      bus.cipher  = CT0;
      @(negedge clk);
      bus.newKey  = 1'b0;
      bus.newData = 1'b0;
      check("both ldKey", 64'(bus.ldKey), 64'd1);
      check("both ldData", 64'(bus.ldData), 64'd1);
      wait_data(cyc);
      check("both latency", 64'(cyc), 64'd60);
      check("both plain", 64'(bus.plain), 64'(PT0));
      release_data("both");

      // reset in the middle of DEC
      @(negedge clk);
      bus.newData = 1'b1;
      bus.cipher  = c2;
      @(negedge clk);
      bus.newData = 1'b0;
      repeat (10) @(negedge clk);
      R = 1'b1;
      #1;
      check("midrst ldData", 64'(bus.ldData), 64'd0);
      check("midrst doneKey", 64'(bus.doneKey), 64'd0);
      check("midrst doneData", 64'(bus.doneData), 64'd0);
      check("midrst busy", 64'(bus.busy), 64'd0);
      check("midrst plain", 64'(bus.plain), 64'd0);
      @(negedge clk);
      R = 1'b0;
      @(negedge clk);
      bus.newData = 1'b1;
      bus.cipher  = CT0;
      @(negedge clk);
      bus.newData = 1'b0;
      check("postrst ldData", 64'(bus.ldData), 64'd0);
      repeat (40) @(negedge clk);
      check("postrst doneData", 64'(bus.doneData), 64'd0);
      check("postrst busy", 64'(bus.busy), 64'd0);

`ifdef SIMON_DEC_ENCRYPT_EN
      load_key(K0, "enc");
      bus.enc_dec = 1'b1;
      run_data(PT0, CT0, "enc known");
      bus.enc_dec = 1'b0;
      run_data(CT0, PT0, "enc back");
      c1 = $urandom();
      e1 = model_enc(K0, c1);
      bus.enc_dec = 1'b1;
      run_data(c1, e1, "enc rnd");
      bus.enc_dec = 1'b0;
      run_data(e1, c1, "enc rnd back");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
